// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor built around a single full-adder slice.
// Operands stream LSB-first, one bit per clock, with a registered carry between bits.

module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             slice_sum;
  logic             slice_cout;

  // One bit of the operation per clock; carry is closed through the carry register.
  fulladder u_slice (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // Sequencer: loads on Start, shifts WIDTH bits, then pulses Done for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      Result   <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          Busy <= 1'b0;
          if (Start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with Sub.
            a_sh     <= A;
            b_sh     <= B ^ {WIDTH{Sub}};
            carry    <= Sub;
            cnt      <= '0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            Busy     <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          Result <= {slice_sum, Result[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= slice_cout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // carry holds the carry into the MSB at this point.
            Cout     <= slice_cout;
            Overflow <= carry ^ slice_cout;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed, table-driven bench for serial_addsub at WIDTH=8.

module tb_serial_addsub;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         Start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Result;
  logic         Cout;
  logic         Overflow;
  logic         Busy;
  logic         Done;

  int tests;
  int fails;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Sub      (Sub),
    .A        (A),
    .B        (B),
    .Result   (Result),
    .Cout     (Cout),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one operation from cycle 0 and checks timing and results through cycle W+2.
  task automatic run_op(input vec_t v, input int idx);
    logic timing_ok;
    A     = v.a;
    B     = v.b;
    Sub   = v.sub;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    A     = ~v.a;
    B     = ~v.b;
    Sub   = ~v.sub;
    timing_ok = 1'b1;
    for (int c = 1; c <= int'(W); c++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) timing_ok = 1'b0;
      tick();
    end
    check($sformatf("v%0d shift busy/nodone", idx), 32'(timing_ok), 32'd1);
    check($sformatf("v%0d done", idx), 32'(Done), 32'd1);
    check($sformatf("v%0d busy_in_done", idx), 32'(Busy), 32'd1);
    check($sformatf("v%0d result", idx), 32'(Result), 32'(v.res));
    check($sformatf("v%0d cout", idx), 32'(Cout), 32'(v.cout));
    check($sformatf("v%0d overflow", idx), 32'(Overflow), 32'(v.ovf));
    tick();
    check($sformatf("v%0d idle done", idx), 32'(Done), 32'd0);
    check($sformatf("v%0d idle busy", idx), 32'(Busy), 32'd0);
    check($sformatf("v%0d result held", idx), 32'(Result), 32'(v.res));
  endtask

  initial begin
    logic ok;
    vec_t v;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    Start = 1'b0;
    Sub   = 1'b0;
    A     = '0;
    B     = '0;

    vecs[0] = '{a: 8'h64, b: 8'h37, sub: 1'b0, res: 8'h9B, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hC8, b: 8'h64, sub: 1'b0, res: 8'h2C, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h32, b: 8'h50, sub: 1'b1, res: 8'hE2, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, res: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[7] = '{a: 8'hFF, b: 8'hFF, sub: 1'b1, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[8] = '{a: 8'h00, b: 8'h01, sub: 1'b1, res: 8'hFF, cout: 1'b0, ovf: 1'b0};
    vecs[9] = '{a: 8'hFF, b: 8'hFF, sub: 1'b0, res: 8'hFE, cout: 1'b1, ovf: 1'b0};

    // Reset for two cycles, then idle for five.
    tick();
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (Result !== '0 || Cout !== 1'b0 || Overflow !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0)
        ok = 1'b0;
      tick();
    end
    check("reset idle outputs", 32'(ok), 32'd1);

    for (int i = 0; i < 10; i++) run_op(vecs[i], i);

    // Start while busy is ignored.
    A = 8'h01; B = 8'h01; Sub = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    A = 8'hFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    ok = 1'b1;
    for (int c = 4; c <= int'(W); c++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) ok = 1'b0;
      tick();
    end
    check("busy start timing", 32'(ok), 32'd1);
    check("busy start done", 32'(Done), 32'd1);
    check("busy start result", 32'(Result), 32'h02);
    check("busy start cout", 32'(Cout), 32'd0);
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (Busy !== 1'b0 || Done !== 1'b0) ok = 1'b0;
    end
    check("busy start no relaunch", 32'(ok), 32'd1);

    // Reset mid-operation aborts with no Done.
    A = 8'hC8; B = 8'h64; Sub = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst result", 32'(Result), 32'd0);
    check("midrst flags", 32'({Cout, Overflow, Busy, Done}), 32'd0);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < int'(W) + 3; c++) begin
      if (Done !== 1'b0 || Busy !== 1'b0 || Result !== '0) ok = 1'b0;
      tick();
    end
    check("midrst no done", 32'(ok), 32'd1);
    v = '{a: 8'h32, b: 8'h50, sub: 1'b1, res: 8'hE2, cout: 1'b0, ovf: 1'b0};
    run_op(v, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor.
- Loads two operands on a start handshake.
- Streams them LSB-first through a single combinational full-adder bit slice, one bit per clock, with a registered carry. The existing fulladder cell is instantiated as that slice.
- Produces an N-bit result with carry-out and signed-overflow flags. It sits upstream of the full-adder cell, sequencing its A/B/Cin inputs and collecting its Sum/Cout outputs.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- Start  input  1  request; accepted only in IDLE.
- Sub  input  1  0 = add, 1 = subtract (A - B); sampled with Start.
- A  input  WIDTH  operand A; sampled with Start.
- B  input  WIDTH  operand B; sampled with Start.
- Result  output  WIDTH  sum/difference; registered; held until next accepted Start.
- Cout  output  1  final carry; for Sub it is the no-borrow flag (1 when A >= B unsigned).
- Overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- Busy  output  1  high in SHIFT and DONE.
- Done  output  1  one-cycle pulse when Result, Cout and Overflow become valid.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - Result, Cout, Overflow, Busy and Done all go to 0.
  - Internal shift registers, carry and bit counter go to 0.
  - Reset mid-operation aborts: no Done pulse, Result forced to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Busy=0, Done=0; outputs hold their last values.
  - On Start=1:
    - a_sh <= A.
    - b_sh <= B XOR {WIDTH{Sub}}.
    - carry <= Sub.
    - cnt <= 0.
    - Result, Cout, Overflow cleared to 0.
    - Next state SHIFT.
- SHIFT, each cycle:
  - Slice inputs: a_sh[0], b_sh[0], carry.
  - Result shifts right with the slice Sum inserted at bit WIDTH-1.
  - a_sh and b_sh shift right.
  - carry <= slice Cout.
  - cnt increments.
  - When cnt == WIDTH-1 (MSB slice):
    - Cout <= slice Cout.
    - Overflow <= carry XOR slice Cout.
    - Next state DONE.
- DONE:
  - Done=1 for exactly this cycle; Busy=1.
  - Next state IDLE unconditionally.
- Timing:
  - Start accepted at the edge ending cycle 0.
  - SHIFT occupies cycles 1..WIDTH.
  - Done=1 in cycle WIDTH+1.
  - Result, Cout and Overflow are valid from cycle WIDTH+1 and stable until the next accepted Start.
  - Minimum Start-to-Start spacing is WIDTH+2 cycles.
- Start while Busy=1 is ignored; the in-flight operation is not disturbed.
- A, B and Sub changes after acceptance have no effect.
- Arithmetic:
  - Result = (A + B) mod 2^WIDTH, or (A + ~B + 1) mod 2^WIDTH.
  - Carry is never added beyond WIDTH bits.
- Operands 0 and all-ones need no special handling.
- The slice is combinational; the clock period must exceed the slice's worst-case path (carry-in to Cout/Sum).

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, Start=0 for 5 cycles -> Result=0, Cout=0, Overflow=0, Busy=0, Done=0 throughout.
- Add with signed overflow: WIDTH=8, A=0x64, B=0x37, Sub=0, Start in cycle 0 -> Busy cycles 1..9, Done=1 only in cycle 9, Result=0x9B, Cout=0, Overflow=1.
- Add with carry, no overflow: A=0xC8, B=0x64, Sub=0 -> Result=0x2C, Cout=1, Overflow=0.
- Subtract with borrow: A=0x32, B=0x50, Sub=1 -> Result=0xE2, Cout=0, Overflow=0.
- Subtract with overflow: A=0x80, B=0x01, Sub=1 -> Result=0x7F, Cout=1, Overflow=1.
- Start while busy and reset mid-operation:
  - Start A=0x01, B=0x01; re-pulse Start with A=0xFF in cycle 3 -> ignored, Result=0x02 at cycle 9.
  - New op, assert rst_n=0 in cycle 4 -> no Done, all outputs 0, next Start runs normally.
